// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Shares the single line-wide physical memory port between the I-cache and
//   the D-cache. Level-held requests are granted one at a time, the command,
//   address and write data are latched and held until pmem_resp, and the
//   returned line is handed back with a one-cycle resp pulse to the winner.
//
//   Optional feature: define PMEM_ARB_ROUND_ROBIN_EN to alternate contested
//   grants using a last-grant register. Without it, the D-cache always wins
//   contested grants.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   icache_read/address           I-cache line read request (held until resp)
//   icache_resp/rdata             I-cache completion pulse and returned line
//   dcache_read/write/address     D-cache line read / writeback request
//   dcache_wdata                  D-cache writeback line
//   dcache_resp/rdata             D-cache completion pulse and returned line
//   pmem_read/write/address/wdata registered memory command bus
//   pmem_resp/rdata               memory completion and read data
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    output logic                  icache_resp,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic                  dcache_resp,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

    state_t                state, state_nx;
    logic                  winner_d;   // current transaction belongs to the D-cache
    logic [LINE_WIDTH-1:0] line_q;
    logic                  dcache_req;
    logic                  any_req;
    logic                  grant_d;

    assign dcache_req = dcache_read | dcache_write;
    assign any_req    = icache_read | dcache_req;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    logic last_d;   // last grant went to the D-cache

    // Contested: hand the grant to whoever did not win last time.
    always_comb begin
        grant_d = dcache_req;
        if (icache_read && dcache_req)
            grant_d = ~last_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_d <= 1'b0;
        else if (state == IDLE && any_req)
            last_d <= grant_d;
    end
`else
    // Fixed priority: any D-cache request beats the I-cache.
    assign grant_d = dcache_req;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req)   state_nx = BUSY;
            BUSY:    if (pmem_resp) state_nx = RESPOND;
            RESPOND:                state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Command bus and line register. Requester inputs are only sampled at
    // the grant, so changes during BUSY never reach memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner_d     <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            line_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        winner_d     <= grant_d;
                        pmem_address <= grant_d ? dcache_address : icache_address;
                        if (grant_d)
                            pmem_wdata <= dcache_wdata;
                        // read+write together is treated as a writeback
                        pmem_write   <= grant_d & dcache_write;
                        pmem_read    <= ~(grant_d & dcache_write);
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        line_q     <= pmem_rdata;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Responses decode straight from state so reset clears them at once.
    assign icache_resp  = (state == RESPOND) & ~winner_d;
    assign dcache_resp  = (state == RESPOND) &  winner_d;
    assign icache_rdata = line_q;
    assign dcache_rdata = line_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter
//   Bench for pmem_arbiter with a behavioural line memory. Expected grant
//   order and returned lines come from a transaction-level model that keeps
//   its own copy of memory contents and the last-grant history.
//   The memory returns the stored line after applying any write.
module tb_pmem_arbiter;

    localparam int AW = 16;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          icache_read, dcache_read, dcache_write;
    logic [AW-1:0] icache_address, dcache_address;
    logic [LW-1:0] dcache_wdata;
    logic          icache_resp, dcache_resp;
    logic [LW-1:0] icache_rdata, dcache_rdata;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_resp = 1'b0;
    logic [LW-1:0] pmem_rdata = '0;

    pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_resp(icache_resp), .icache_rdata(icache_rdata),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural physical memory ----------------
    logic [LW-1:0] mem [0:2047];
    bit  mem_ready = 1'b0;
    bit  mem_en    = 1'b1;
    bit  stray     = 1'b0;   // toggled by the test to inject an unsolicited resp
    bit  stray_seen = 1'b0;
    int  mem_cnt = 0;
    int  mem_lat = 2;

    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 2048; i++) mem[i] = {8{i}};
            mem[2] = {32{8'hA5}};
            mem_ready = 1'b1;
        end
        if (pmem_resp) begin
            pmem_resp = 1'b0;          // respond state: commands ignored here
        end else if (stray != stray_seen) begin
            stray_seen = stray;
            pmem_rdata = {32{8'hEE}};
            pmem_resp  = 1'b1;
        end else if (mem_en && (pmem_read || pmem_write)) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                if (pmem_write) mem[pmem_address[15:5]] = pmem_wdata;
                pmem_rdata = mem[pmem_address[15:5]];
                pmem_resp  = 1'b1;
                mem_cnt    = 0;
                mem_lat    = $urandom_range(1, 4);
            end
        end else begin
            mem_cnt = 0;
        end
    end

    // Two command-free cycles must follow every pmem_resp.
    always @(posedge clk) begin
        if (pmem_resp && !rst) begin
            #1;
            chk1("gap1_cmd", pmem_read | pmem_write, 1'b0);
            @(posedge clk);
            #1;
            chk1("gap2_cmd", pmem_read | pmem_write, 1'b0);
        end
    end

    // ---------------- transaction-level reference model ----------------
    logic [LW-1:0] ref_mem [0:2047];
    bit            ref_last_d = 1'b0;

    // Predicts grant order and returned lines for one round of requests.
    task automatic model_round(input bit ir, input bit dr, input bit dw,
                               input logic [AW-1:0] ia, input logic [AW-1:0] da,
                               input logic [LW-1:0] wd,
                               output bit first, output logic [LW-1:0] ird,
                               output logic [LW-1:0] drd);
        bit d = dr | dw;
        ird = '0;
        drd = '0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        first = (ir && d) ? ~ref_last_d : d;
`else
        first = d;
`endif
        if (first) begin
            if (dw) ref_mem[da[15:5]] = wd;
            drd = ref_mem[da[15:5]];
            if (ir) ird = ref_mem[ia[15:5]];
        end else begin
            ird = ref_mem[ia[15:5]];
            if (d) begin
                if (dw) ref_mem[da[15:5]] = wd;
                drd = ref_mem[da[15:5]];
            end
        end
        ref_last_d = (ir && d) ? ~first : d;
    endtask

    // Presents a round of requests, behaves like the caches (drop after
    // resp), and checks commands and responses against the expectations.
    task automatic round(input bit ir, input bit dr, input bit dw,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input logic [LW-1:0] wd, input bit first,
                         input logic [LW-1:0] eird, input logic [LW-1:0] edrd);
        int n = int'(ir) + int'(dr | dw);
        bit ord [2];
        int k = 0;
        int cyc = 0;
        bit seen = 1'b0;
        logic          ew;
        logic [AW-1:0] ea;
        logic [LW-1:0] erd;
        ord[0] = first;
        ord[1] = ~first;
        @(negedge clk);
        icache_read = ir;  icache_address = ia;
        dcache_read = dr;  dcache_write = dw;
        dcache_address = da;  dcache_wdata = wd;
        while (k < n && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            ew  = ord[k] ? dw : 1'b0;
            ea  = ord[k] ? da : ia;
            erd = ord[k] ? edrd : eird;
            if (!seen && (pmem_read || pmem_write)) begin
                seen = 1'b1;
                chk1("cmd_write", pmem_write, ew);
                chk1("cmd_read", pmem_read, ~ew);
                chka("cmd_addr", pmem_address, ea);
                if (ew) chkv("cmd_wdata", pmem_wdata, wd);
            end else if (seen && ew) begin
                chk1("write_no_read", pmem_read, 1'b0);
            end
            if (icache_resp || dcache_resp) begin
                chka("resp_who", AW'({dcache_resp, icache_resp}), ord[k] ? AW'(2) : AW'(1));
                chkv("resp_rdata", ord[k] ? dcache_rdata : icache_rdata, erd);
                chkv("rdata_both", icache_rdata, dcache_rdata);
                if (ord[k]) begin
                    dcache_read  = 1'b0;
                    dcache_write = 1'b0;
                end else begin
                    icache_read = 1'b0;
                end
                k++;
                seen = 1'b0;
            end
        end
        if (k < n) begin
            checks++;
            errors++;
            $display("FAIL round_timeout got=%0d resps required=%0d", k, n);
            icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
        end
        @(posedge clk);
        #1;
        chka("resp_one_cycle", AW'({dcache_resp, icache_resp}), AW'(0));
    endtask

    typedef struct {
        bit            ir, dr, dw;
        logic [AW-1:0] ia, da;
        logic [LW-1:0] wd;
        bit            first;
        logic [LW-1:0] ird, drd;
    } vec_t;

    vec_t tbl [8];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : test
        bit            mf;
        logic [LW-1:0] mi, md;
        logic [LW-1:0] line_a5, line_1234, line_5a, line_c3;
        bit            who [2];
        int            k, cyc;

        line_a5   = {32{8'hA5}};
        line_1234 = {16{16'h1234}};
        line_5a   = {32{8'h5A}};
        line_c3   = {32{8'hC3}};
        for (int i = 0; i < 2048; i++) ref_mem[i] = {8{i}};
        ref_mem[2] = line_a5;

        //          ir dr dw  ia        da        wd         first ird        drd
        tbl[0] = '{1, 0, 0, 16'h0040, 16'h0000, '0,        0, line_a5,   '0};
        tbl[1] = '{0, 0, 1, 16'h0000, 16'h1FE0, line_1234, 1, '0,        line_1234};
        tbl[2] = '{1, 0, 0, 16'h1FE0, 16'h0000, '0,        0, line_1234, '0};
        tbl[3] = '{0, 1, 1, 16'h0000, 16'h0400, line_5a,   1, '0,        line_5a};
        tbl[4] = '{0, 1, 0, 16'h0000, 16'h0400, '0,        1, '0,        line_5a};
        tbl[5] = '{1, 0, 0, 16'h0041, 16'h0000, '0,        0, line_a5,   '0};
        tbl[6] = '{1, 0, 1, 16'h0040, 16'h1FE0, line_c3,   1, line_a5,   line_c3};
        tbl[7] = '{1, 1, 0, 16'h1FE0, 16'h0040, '0,        1, line_c3,   line_a5};

        rst = 1'b1;
        icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
        icache_address = '0; dcache_address = '0; dcache_wdata = '0;
        #1;
        chk1("rst_pmem_read", pmem_read, 1'b0);
        chk1("rst_pmem_write", pmem_write, 1'b0);
        chka("rst_pmem_address", pmem_address, '0);
        chkv("rst_pmem_wdata", pmem_wdata, '0);
        chk1("rst_icache_resp", icache_resp, 1'b0);
        chk1("rst_dcache_resp", dcache_resp, 1'b0);
        chkv("rst_rdata", icache_rdata, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First command appears exactly one cycle after the grant edge.
        @(negedge clk);
        icache_read = 1'b1; icache_address = 16'h0040;
        @(posedge clk);
        #1;
        chk1("latency_cmd_n1", pmem_read, 1'b1);
        chka("latency_addr_n1", pmem_address, 16'h0040);
        cyc = 0;
        while (!icache_resp && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk1("latency_resp", icache_resp, 1'b1);
        chkv("latency_rdata", icache_rdata, line_a5);
        icache_read = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            model_round(tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].ia, tbl[i].da,
                        tbl[i].wd, mf, mi, md);
            round(tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].ia, tbl[i].da,
                  tbl[i].wd, tbl[i].first, tbl[i].ird, tbl[i].drd);
        end

        // Both caches keep requesting across two grants.
        @(negedge clk);
        icache_read = 1'b1; icache_address = 16'h0040;
        dcache_read = 1'b1; dcache_address = 16'h0400;
        k = 0; cyc = 0;
        while (k < 2 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (icache_resp || dcache_resp) begin
                who[k] = dcache_resp;
                chkv("hold_rdata", dcache_resp ? dcache_rdata : icache_rdata,
                     dcache_resp ? line_5a : line_a5);
                k++;
            end
        end
        icache_read = 1'b0; dcache_read = 1'b0;
        chka("hold_count", AW'(k), AW'(2));
        chk1("hold_grant0", who[0], 1'b1);
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        chk1("hold_grant1", who[1], 1'b0);
        ref_last_d = 1'b0;
`else
        chk1("hold_grant1", who[1], 1'b1);
        ref_last_d = 1'b1;
`endif
        repeat (3) @(posedge clk);

        // Reset while BUSY, then an unsolicited memory response.
        mem_en = 1'b0;
        @(negedge clk);
        icache_read = 1'b1; icache_address = 16'h0080;
        cyc = 0;
        while (!pmem_read && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk1("rbusy_reached", pmem_read, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk1("rbusy_pmem_read", pmem_read, 1'b0);
        chk1("rbusy_pmem_write", pmem_write, 1'b0);
        chka("rbusy_pmem_address", pmem_address, '0);
        chkv("rbusy_pmem_wdata", pmem_wdata, '0);
        chka("rbusy_resp", AW'({dcache_resp, icache_resp}), AW'(0));
        chkv("rbusy_rdata", icache_rdata, '0);
        icache_read = 1'b0;
        ref_last_d = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        stray = ~stray;
        repeat (4) begin
            @(posedge clk);
            #1;
            chka("stray_no_resp", AW'({dcache_resp, icache_resp}), AW'(0));
        end
        chkv("stray_no_capture", dcache_rdata, '0);
        mem_en = 1'b1;
        model_round(1'b1, 1'b0, 1'b0, 16'h0080, 16'h0000, '0, mf, mi, md);
        round(1'b1, 1'b0, 1'b0, 16'h0080, 16'h0000, '0, mf, mi, md);

        // Randomised rounds against the model.
        for (int r = 0; r < 40; r++) begin
            bit            ir, dr, dw;
            logic [AW-1:0] ia, da;
            logic [LW-1:0] wd;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            if (!ir && !dr && !dw) ir = 1'b1;
            ia = AW'(($urandom_range(0, 7) << 5) | $urandom_range(0, 31));
            da = AW'(($urandom_range(0, 7) << 5) | $urandom_range(0, 31));
            wd = {8{$urandom()}};
            model_round(ir, dr, dw, ia, da, wd, mf, mi, md);
            round(ir, dr, dw, ia, da, wd, mf, mi, md);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Sequencer that shares the single 256-bit-line physical memory port between the instruction cache and the data cache. It accepts level-held line requests from both caches, serialises them onto the memory's read/write/resp handshake, and returns each line with a one-cycle response pulse to the winning requester. It sits between the cache pair and `physical_memory`, and drives that module's ports directly.

## Interface
- `ADDR_WIDTH`, 16: byte address width; bits [4:0] are ignored by memory.
- `LINE_WIDTH`, 256: cache line width in bits.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `icache_read`  in  1  I-cache line read request; held until `icache_resp`.
- `icache_address`  in  ADDR_WIDTH  I-cache line address.
- `icache_resp`  out  1  one-cycle completion pulse to I-cache.
- `icache_rdata`  out  LINE_WIDTH  returned line; valid in the cycle `icache_resp` is high.
- `dcache_read`  in  1  D-cache line read request; held until `dcache_resp`.
- `dcache_write`  in  1  D-cache line writeback request; held until `dcache_resp`.
- `dcache_address`  in  ADDR_WIDTH  D-cache line address.
- `dcache_wdata`  in  LINE_WIDTH  writeback line.
- `dcache_resp`  out  1  one-cycle completion pulse to D-cache.
- `dcache_rdata`  out  LINE_WIDTH  returned line; valid in the cycle `dcache_resp` is high.
- `pmem_read`, `pmem_write`  out  1  memory commands; registered.
- `pmem_address`  out  ADDR_WIDTH  registered memory address.
- `pmem_wdata`  out  LINE_WIDTH  registered memory write data.
- `pmem_resp`  in  1  memory completion.
- `pmem_rdata`  in  LINE_WIDTH  memory read data; valid with `pmem_resp`.

## Operation
- FSM states: IDLE, BUSY, RESPOND.
- IDLE: if any request is pending, choose a winner. Latch the winner ID, address, and wdata. Latch the command: `pmem_write` if `dcache_write`, else `pmem_read`. Go to BUSY. With no request, stay in IDLE with all pmem commands low.
- BUSY: drive the latched command, address, and wdata. Requester inputs are ignored; changes are not forwarded. On `pmem_resp`: capture `pmem_rdata` into the line register, clear both pmem commands, and go to RESPOND.
- RESPOND: pulse the winner's `*_resp` for exactly one cycle. The winner's `*_rdata` shows the captured line; the loser's resp stays 0. Then go to IDLE.
- `dcache_read` and `dcache_write` together: treated as a write; memory rdata is still returned.
- The line register holds its value until the next capture; both `*_rdata` outputs show it.
- Priority on simultaneous requests: see Configuration. A single pending request always wins immediately.

## Timing
- Reset values: `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, `icache_resp`=0, `dcache_resp`=0, line register=0, state IDLE, last-grant=I-cache.
- Request seen in IDLE at edge N: pmem command is high from cycle N+1.
- `pmem_resp` sampled at edge M: commands are low and client resp is high in cycle M+1. The next grant is evaluated at edge M+2, so the earliest new pmem command is in cycle M+3.
- Round-trip overhead added by the arbiter: 3 cycles per transaction beyond memory latency.
- The 2-cycle command-low gap after `pmem_resp` is required: memory ignores commands in its respond state.
- Requesters drop their request in the cycle after their resp pulse. A request still high at edge M+2 is treated as a new request.
- Reset mid-transaction: all outputs return to reset values immediately; the in-flight transaction is abandoned. Memory completes its own cycle independently, and any `pmem_resp` arriving in IDLE is ignored.

## Configuration
- `PMEM_ARB_ROUND_ROBIN_EN` defined: on simultaneous requests, grant the requester not named in the last-grant register. Last-grant updates on every grant and resets to I-cache, so the first contested grant goes to D-cache.
- Not defined: fixed priority; D-cache always wins contested grants. The last-grant register is not implemented.

## Test plan
- I-cache read only, address 0x0040; memory returns 0xA5..A5 → `pmem_read` high with address 0x0040 one cycle after request; `icache_resp` pulses once with rdata 0xA5..A5; `dcache_resp` stays 0.
- D-cache write, address 0x1FE0, wdata 0x1234..; then I-cache read of 0x1FE0 → memory stores the line; the later `icache_rdata` equals 0x1234...
- Both request in the same cycle, two times in a row → without the macro, grant order D, D; with the macro, grant order D, I.
- `dcache_read` and `dcache_write` both high → only `pmem_write` asserted; `pmem_read` stays 0 throughout.
- After every `pmem_resp`, check the next 2 cycles → both pmem commands are 0; the next command starts no earlier than cycle M+3.
- `rst` pulsed while BUSY → outputs go to 0 the same cycle with no clock edge needed; a late `pmem_resp` produces no client resp; the next request is served normally.
